// File: rtl/intra4x4_scheduler_if.sv
// Handshake and control bundle between the intra 4x4 scheduler and the
// frame controller / extractor / predictor / reconstruction chain.
interface intra4x4_scheduler_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        ext_enable;
    logic [12:0] blk_number;
    logic [3:0]  blk_idx;
    logic [12:0] mb_number;
    logic        blk_valid;
    logic        blk_ready;
    logic        recon_done;

    modport master (
        input  start, blk_ready, recon_done,
        output busy, done, ext_enable, blk_number, blk_idx, mb_number, blk_valid
    );

    modport slave (
        output start, blk_ready, recon_done,
        input  busy, done, ext_enable, blk_number, blk_idx, mb_number, blk_valid
    );
endinterface

// File: rtl/intra4x4_scheduler.sv
// Walks every 4x4 luma block of a frame: fetch via extractor, issue to predictor,
// stall until reconstruction. Define INTRA4X4_ZORDER_EN for z-scan order in an MB.
module intra4x4_scheduler #(
    parameter int LENGTH      = 256,
    parameter int WIDTH       = 256,
    parameter int EXT_LATENCY = 2
) (
    input logic                  clk,
    input logic                  reset,
    intra4x4_scheduler_if.master bus
);
    localparam logic [12:0] MB_COLS  = 13'(WIDTH / 16);
    localparam logic [12:0] MB_ROWS  = 13'(LENGTH / 16);
    localparam logic [12:0] BLK_COLS = 13'(WIDTH / 4);
    localparam logic [7:0]  LAT_LAST = 8'(EXT_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_RECON, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  lat_q, lat_d;
    logic [12:0] mb_x_q, mb_x_d;
    logic [12:0] mb_y_q, mb_y_d;
    logic [3:0]  idx_q, idx_d;
    logic        busy_q, done_q, ext_en_q, valid_q;
    logic [12:0] blk_num_q, mb_num_q;
    logic        last_blk;

    function automatic logic [1:0] blk_bx(input logic [3:0] idx);
`ifdef INTRA4X4_ZORDER_EN
        return {idx[2], idx[0]};
`else
        return idx[1:0];
`endif
    endfunction

    function automatic logic [1:0] blk_by(input logic [3:0] idx);
`ifdef INTRA4X4_ZORDER_EN
        return {idx[3], idx[1]};
`else
        return idx[3:2];
`endif
    endfunction

    function automatic logic [12:0] blk_raster(input logic [12:0] mbx, input logic [12:0] mby,
                                               input logic [3:0] idx);
        logic [12:0] bx, by;
        bx = (mbx << 2) + {11'd0, blk_bx(idx)};
        by = (mby << 2) + {11'd0, blk_by(idx)};
        return by * BLK_COLS + bx;
    endfunction

    assign last_blk = (mb_x_q == MB_COLS - 13'd1) && (mb_y_q == MB_ROWS - 13'd1) &&
                      (idx_q == 4'd15);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        mb_x_d  = mb_x_q;
        mb_y_d  = mb_y_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    lat_d   = 8'd0;
                    mb_x_d  = 13'd0;
                    mb_y_d  = 13'd0;
                    idx_d   = 4'd0;
                end
            end
            FETCH: begin
                if (lat_q == LAT_LAST) state_d = ISSUE;
                else                   lat_d   = lat_q + 8'd1;
            end
            // blk_valid is high for the whole of ISSUE, so ready alone completes the handshake
            ISSUE: begin
                if (bus.blk_ready) state_d = WAIT_RECON;
            end
            WAIT_RECON: begin
                if (bus.recon_done) begin
                    if (last_blk) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        lat_d   = 8'd0;
                        idx_d   = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            if (mb_x_q == MB_COLS - 13'd1) begin
                                mb_x_d = 13'd0;
                                mb_y_d = mb_y_q + 13'd1;
                            end else begin
                                mb_x_d = mb_x_q + 13'd1;
                            end
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lat_q     <= 8'd0;
            mb_x_q    <= 13'd0;
            mb_y_q    <= 13'd0;
            idx_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ext_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            blk_num_q <= 13'd0;
            mb_num_q  <= 13'd0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            mb_x_q    <= mb_x_d;
            mb_y_q    <= mb_y_d;
            idx_q     <= idx_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            ext_en_q  <= (state_d == FETCH);
            valid_q   <= (state_d == ISSUE);
            blk_num_q <= blk_raster(mb_x_d, mb_y_d, idx_d);
            mb_num_q  <= mb_y_d * MB_COLS + mb_x_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ext_enable = ext_en_q;
    assign bus.blk_valid  = valid_q;
    assign bus.blk_number = blk_num_q;
    assign bus.blk_idx    = idx_q;
    assign bus.mb_number  = mb_num_q;
endmodule

// File: tb/tb_intra4x4_scheduler.sv
// Bench for intra4x4_scheduler: a 256x256 instance and a 32x32 instance share
// the clock/reset; sel routes stimulus to one of them at a time.
module tb_intra4x4_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic sel = 1'b0;
    logic start_drv = 1'b0, ready_drv = 1'b0, recon_drv = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seen[$];

    intra4x4_scheduler_if ifb();
    intra4x4_scheduler_if ifs();

    assign ifb.start      = start_drv & ~sel;
    assign ifb.blk_ready  = ready_drv & ~sel;
    assign ifb.recon_done = recon_drv & ~sel;
    assign ifs.start      = start_drv & sel;
    assign ifs.blk_ready  = ready_drv & sel;
    assign ifs.recon_done = recon_drv & sel;

    intra4x4_scheduler dut_b (.clk(clk), .reset(reset), .bus(ifb.master));
    intra4x4_scheduler #(.LENGTH(32), .WIDTH(32), .EXT_LATENCY(2))
        dut_s (.clk(clk), .reset(reset), .bus(ifs.master));

    logic        o_busy, o_done, o_ext, o_valid;
    logic [12:0] o_num, o_mb;
    logic [3:0]  o_idx;
    assign o_busy  = sel ? ifs.busy       : ifb.busy;
    assign o_done  = sel ? ifs.done       : ifb.done;
    assign o_ext   = sel ? ifs.ext_enable : ifb.ext_enable;
    assign o_valid = sel ? ifs.blk_valid  : ifb.blk_valid;
    assign o_num   = sel ? ifs.blk_number : ifb.blk_number;
    assign o_mb    = sel ? ifs.mb_number  : ifb.mb_number;
    assign o_idx   = sel ? ifs.blk_idx    : ifb.blk_idx;

    typedef struct {
        logic start, ready, recon;
        logic busy, ext, valid, done;
        int   num, idx;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start_drv = 1'b0;
        ready_drv = 1'b0;
        recon_drv = 1'b0;
    endtask

    // Reference: k-th block of the frame in processing order -> raster 4x4 block number
    function automatic int exp_blk(input int k, input int w);
        int mb, idx, mbx, mby, bx, by;
        mb  = k / 16;
        idx = k % 16;
        mbx = mb % (w / 16);
        mby = mb / (w / 16);
`ifdef INTRA4X4_ZORDER_EN
        bx = ((idx >> 2) & 1) * 2 + (idx & 1);
        by = ((idx >> 3) & 1) * 2 + ((idx >> 1) & 1);
`else
        bx = idx % 4;
        by = idx / 4;
`endif
        return (mby * 4 + by) * (w / 4) + mbx * 4 + bx;
    endfunction

    task automatic run_blocks(input int nblk, input int w, input bit full);
        int t, d;
        start_drv = 1'b1;
        step();
        start_drv = 1'b0;
        for (int k = 0; k < nblk; k++) begin
            t = 0;
            while (o_valid !== 1'b1 && t < 40) begin
                start_drv = 1'($urandom_range(0, 1));
                ready_drv = 1'($urandom_range(0, 1));
                recon_drv = 1'($urandom_range(0, 1));
                step();
                t++;
            end
            quiet();
            check("blk_valid rise", o_valid, 1);
            check("blk_number", o_num, exp_blk(k, w));
            check("blk_idx", o_idx, k % 16);
            check("mb_number", o_mb, k / 16);
            if (w == 256 && seen.size() < 9) seen.push_back(int'(o_num));
            d = $urandom_range(0, 3);
            repeat (d) begin
                recon_drv = 1'($urandom_range(0, 1));
                step();
            end
            check("valid held", o_valid, 1);
            check("number held", o_num, exp_blk(k, w));
            ready_drv = 1'b1;
            recon_drv = 1'($urandom_range(0, 1));
            step();
            quiet();
            check("valid drop", o_valid, 0);
            d = $urandom_range(0, 4);
            repeat (d) begin
                start_drv = 1'($urandom_range(0, 1));
                ready_drv = 1'($urandom_range(0, 1));
                step();
            end
            quiet();
            check("no fetch before recon", o_ext, 0);
            check("number in wait", o_num, exp_blk(k, w));
            recon_drv = 1'b1;
            step();
            recon_drv = 1'b0;
            if (full && k == nblk - 1) begin
                check("done pulse", o_done, 1);
                check("busy during done", o_busy, 1);
                check("last blk_number", o_num, exp_blk(k, w));
                check("last mb_number", o_mb, k / 16);
                step();
                check("done cleared", o_done, 0);
                check("busy dropped", o_busy, 0);
                step();
                check("stays idle", o_busy, 0);
            end else begin
                check("next fetch", o_ext, 1);
                check("no early done", o_done, 0);
                check("next blk_number", o_num, exp_blk(k + 1, w));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int ord[9];
        //                start rdy rc  busy ext val done num idx
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1};
`ifdef INTRA4X4_ZORDER_EN
        ord = '{0, 1, 64, 65, 2, 3, 66, 67, 128};
`else
        ord = '{0, 1, 2, 3, 64, 65, 66, 67, 128};
`endif

        reset = 1'b0;
        repeat (3) step();
        check("reset outs big", {ifb.busy, ifb.done, ifb.ext_enable, ifb.blk_valid,
                                 ifb.blk_number, ifb.blk_idx, ifb.mb_number}, 0);
        check("reset outs small", {ifs.busy, ifs.done, ifs.ext_enable, ifs.blk_valid,
                                   ifs.blk_number, ifs.blk_idx, ifs.mb_number}, 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle outs big", {ifb.busy, ifb.done, ifb.ext_enable, ifb.blk_valid,
                                    ifb.blk_number, ifb.blk_idx, ifb.mb_number}, 0);
            check("idle busy small", ifs.busy, 0);
        end

        // First blocks plus ignored start/recon_done/blk_ready, 256x256 instance
        for (int i = 0; i < 11; i++) begin
            start_drv = tbl[i].start;
            ready_drv = tbl[i].ready;
            recon_drv = tbl[i].recon;
            step();
            check($sformatf("vec%0d busy", i), o_busy, tbl[i].busy);
            check($sformatf("vec%0d ext_enable", i), o_ext, tbl[i].ext);
            check($sformatf("vec%0d blk_valid", i), o_valid, tbl[i].valid);
            check($sformatf("vec%0d done", i), o_done, tbl[i].done);
            check($sformatf("vec%0d blk_number", i), o_num, tbl[i].num);
            check($sformatf("vec%0d blk_idx", i), o_idx, tbl[i].idx);
        end
        quiet();

        // Mid-frame reset while waiting for reconstruction of block 1
        reset = 1'b0;
        #1;
        check("abort outs", {o_busy, o_done, o_ext, o_valid, o_num, o_idx, o_mb}, 0);
        step();
        reset = 1'b1;
        start_drv = 1'b1;
        step();
        start_drv = 1'b0;
        check("restart ext_enable", o_ext, 1);
        check("restart blk_number", o_num, 0);
        check("restart blk_idx", o_idx, 0);

        // Backpressure: ready low for 10 cycles once blk_valid is up
        t = 0;
        while (o_valid !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        check("bp valid rise", o_valid, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp valid held", o_valid, 1);
            check("bp number held", o_num, 0);
        end
        ready_drv = 1'b1;
        step();
        check("bp handshake", o_valid, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp single handshake", {o_valid, o_ext, o_idx}, 0);
        end
        ready_drv = 1'b0;
        recon_drv = 1'b1;
        step();
        recon_drv = 1'b0;
        check("bp advance", {o_ext, o_num}, {1'b1, 13'd1});

        reset = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Randomized ordering run on the 256x256 instance (aborted after 40 blocks)
        seen.delete();
        run_blocks(40, 256, 1'b0);
        for (int i = 0; i < 9; i++) check($sformatf("order[%0d]", i), seen[i], ord[i]);
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Full randomized frame on the 32x32 instance
        sel = 1'b1;
        #1;
        run_blocks(64, 32, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/intra4x4_scheduler.md
# intra4x4_scheduler

Sequencer for the intra 4x4 luma path: it walks every 4x4 luma block of a frame, drives the 4x4 extractor's `enable`/`mbnumber` inputs, and presents each fetched block to the 4x4 predictor through a valid/ready handshake. It then stalls until reconstruction of that block completes, because the next block's top/left neighbours depend on it. It sits between the frame-level controller (`start`/`done`) and the extractor/predictor/reconstruction chain.

## Interface
- `LENGTH`, 256: frame height in luma pixels (multiple of 16).
- `WIDTH`, 256: frame width in luma pixels (multiple of 16).
- `EXT_LATENCY`, 2: extractor cycles from first `ext_enable` to valid `mb`/`toppixels`/`leftpixels` (≥1).
- `clk` input 1: clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to process a frame; sampled only in IDLE.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse after the last block's `recon_done`.
- `ext_enable` output 1: extractor enable.
- `blk_number` output 13: raster 4x4-block number to the extractor `mbnumber` port: `blk_y*(WIDTH/4) + blk_x`.
- `blk_idx` output 4: index of the current block within its macroblock (0..15).
- `mb_number` output 13: raster macroblock number: `mb_y*(WIDTH/16) + mb_x`.
- `blk_valid` output 1: extracted block is ready for the predictor.
- `blk_ready` input 1: predictor accepts the block.
- `recon_done` input 1: reconstruction of the issued block has been written back.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_RECON, DONE.
- IDLE: outputs quiet. `start`=1 clears all position counters (`mb_x`, `mb_y`, `blk_idx`) to 0 and moves to FETCH.
- FETCH:
  - `ext_enable`=1 for exactly EXT_LATENCY consecutive cycles.
  - `blk_number` is stable for the whole interval.
  - Then moves to ISSUE.
- ISSUE:
  - `blk_valid`=1, held until `blk_valid && blk_ready` is sampled high.
  - `blk_number`, `blk_idx` and `mb_number` stay stable while `blk_valid` is high.
  - After the handshake, moves to WAIT_RECON.
- WAIT_RECON:
  - Waits for `recon_done`.
  - On `recon_done`: if the block was the last one (`mb_x`=WIDTH/16-1, `mb_y`=LENGTH/16-1, `blk_idx`=15), moves to DONE. Otherwise advances the position and moves to FETCH.
- Position advance:
  - `blk_idx` increments 15→0 with wrap.
  - On wrap, `mb_x` increments.
  - When `mb_x` wraps at WIDTH/16, it returns to 0 and `mb_y` increments.
- Block coordinates: `blk_x = mb_x*4 + bx`, `blk_y = mb_y*4 + by`, where (`bx`, `by`) come from `blk_idx` as defined under Configuration.
- DONE: `done`=1 for one cycle, then IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `recon_done` outside WAIT_RECON, including a `recon_done` coincident with the ISSUE handshake.
  - `blk_ready` outside ISSUE.
- `reset` asserted in any state: immediately forces IDLE and all outputs to 0, aborting the frame. There is no `done` for an aborted frame.

## Timing
- Reset values: `busy`, `done`, `ext_enable`, `blk_valid` = 0; `blk_number`, `blk_idx`, `mb_number` = 0.
- All outputs are registered.
- `start` sampled at edge N: `ext_enable` is high from N+1 through N+EXT_LATENCY, and `blk_valid` rises at N+EXT_LATENCY+1.
- If `blk_ready` is already high when `blk_valid` rises, the handshake completes in that same cycle and `blk_valid` drops on the next edge.
- `recon_done` sampled at edge M (not last block): the next block's `ext_enable` rises at M+1.
- Minimum per-block period: EXT_LATENCY + 2 cycles, plus predictor and reconstruction stalls.
- `recon_done` sampled at edge M (last block): `done` is high for the cycle after M, and `busy` drops one cycle later.

## Configuration
- `INTRA4X4_ZORDER_EN` defined:
  - `blk_idx` follows the H.264 4x4 z-scan order: `bx = {blk_idx[2], blk_idx[0]}`, `by = {blk_idx[3], blk_idx[1]}`.
  - Sequence of (bx,by): (0,0),(1,0),(0,1),(1,1),(2,0),…
- `INTRA4X4_ZORDER_EN` undefined:
  - Raster order within the macroblock: `bx = blk_idx[1:0]`, `by = blk_idx[3:2]`.
  - Sequence of (bx,by): (0,0),(1,0),(2,0),(3,0),(0,1),…
- Macroblock traversal is raster in both builds.

## Test plan
- Reset/idle: hold `reset`=0, then release with `start`=0 → all outputs 0 and `busy`=0 for 20 cycles.
- First block, default parameters, `blk_ready`=1: `start` pulse at edge 0 → `ext_enable` high at cycles 1–2 with `blk_number`=0, `blk_valid` high at cycle 3, `busy` high from cycle 1.
- Ordering, ZORDER build, `recon_done` returned 3 cycles after each handshake: `blk_number` sequence 0, 1, 64, 65, 2, 3, 66, 67, 128… With the macro undefined: 0, 1, 2, 3, 64, 65…
- Backpressure: `blk_ready`=0 for 10 cycles after `blk_valid` rises → `blk_valid` and `blk_number` stable; exactly one handshake; no advance before `recon_done`.
- Ignored inputs: `recon_done` during FETCH/ISSUE and `start` while busy → no state change.
- Full frame, 32x32 parameters: after 64 `recon_done`s → one-cycle `done`, last `blk_number`=63, `mb_number`=3, then IDLE.
- Mid-frame reset: `reset` pulled low while in WAIT_RECON → outputs 0 immediately; a following `start` restarts at `blk_number`=0.
